// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: selector encodings and the
// queued-entry layout at the core's default widths.
package wb_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_PC   = 2'b01;
  localparam logic [1:0] SEL_GPR  = 2'b10;
  localparam logic [1:0] SEL_FPR  = 2'b11;

  localparam int WB_XLEN = 32;
  localparam int WB_RW   = 5;

  typedef struct packed {
    logic [1:0]         sel;
    logic [WB_XLEN-1:0] data;
    logic [WB_RW-1:0]   rd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small per-channel FIFO. Pushes are ignored when full and pops when empty;
// storage is not reset, only pointers and count.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Commit-stage writeback arbiter: NCH queued result channels, one commit per
// cycle, PC redirects first, otherwise round-robin.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int RW    = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [2*NCH-1:0]  in_sel,
  input  logic [XLEN*NCH-1:0] in_data,
  input  logic [RW*NCH-1:0] in_rd,
  output logic [NCH-1:0]    done,
  output logic              pcenable,
  output logic [XLEN-1:0]   next_pc,
  output logic              wgenable,
  output logic [RW-1:0]     wgreg,
  output logic [XLEN-1:0]   wgdata,
  output logic              wfenable,
  output logic [RW-1:0]     wfreg,
  output logic [XLEN-1:0]   wfdata,
  output logic              busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW = 2 + XLEN + RW;

  // Same field order as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [1:0]      sel;
    logic [XLEN-1:0] data;
    logic [RW-1:0]   rd;
  } entry_t;

  entry_t         head [NCH];
  logic [NCH-1:0] empty;
  logic [NCH-1:0] full;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [PW-1:0]  rr_ptr;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    entry_t din;
    assign din = '{sel: in_sel[2*i +: 2], data: in_data[XLEN*i +: XLEN], rd: in_rd[RW*i +: RW]};

    wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign busy     = |(~empty);

  // Stage p0: combinational arbitration over the FIFO heads
  logic          gnt_vld_p0;
  logic          gnt_pc_p0;
  logic [PW-1:0] gnt_p0;
  entry_t        gnt_ent_p0;
  int            idx;

  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_pc_p0  = 1'b0;
    gnt_p0     = '0;
    idx        = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!empty[i] && head[i].sel == SEL_PC) begin
        gnt_pc_p0 = 1'b1;
        gnt_p0    = PW'(i);
      end
    end
    gnt_vld_p0 = gnt_pc_p0;
    if (!gnt_pc_p0) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!empty[idx]) begin
          gnt_vld_p0 = 1'b1;
          gnt_p0     = PW'(idx);
        end
      end
    end
  end

  assign gnt_ent_p0 = head[gnt_p0];

  always_comb begin
    pop = '0;
    if (gnt_vld_p0) pop[gnt_p0] = 1'b1;
  end

  // Stage p1: registered commit strobes, indices and data
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr   <= '0;
      done     <= '0;
      pcenable <= 1'b0;
      next_pc  <= '0;
      wgenable <= 1'b0;
      wgreg    <= '0;
      wgdata   <= '0;
      wfenable <= 1'b0;
      wfreg    <= '0;
      wfdata   <= '0;
    end else begin
      done     <= '0;
      pcenable <= 1'b0;
      wgenable <= 1'b0;
      wfenable <= 1'b0;
      if (gnt_vld_p0) begin
        done[gnt_p0] <= 1'b1;
        if (!gnt_pc_p0) rr_ptr <= (gnt_p0 == PW'(NCH - 1)) ? '0 : gnt_p0 + 1'b1;
        case (gnt_ent_p0.sel)
          SEL_PC: begin
            pcenable <= 1'b1;
            next_pc  <= gnt_ent_p0.data;
          end
          SEL_GPR: begin
            wgenable <= (gnt_ent_p0.rd != '0);
            wgreg    <= gnt_ent_p0.rd;
            wgdata   <= gnt_ent_p0.data;
          end
          SEL_FPR: begin
            wfenable <= 1'b1;
            wfreg    <= gnt_ent_p0.rd;
            wfdata   <= gnt_ent_p0.data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (NCH=3, DEPTH=2).
module tb_wb_arbiter;

  localparam int NCH = 3, DEPTH = 2, XLEN = 32, RW = 5;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [2*NCH-1:0]  in_sel;
  logic [XLEN*NCH-1:0] in_data;
  logic [RW*NCH-1:0] in_rd;
  logic [NCH-1:0]    done;
  logic              pcenable, wgenable, wfenable, busy;
  logic [XLEN-1:0]   next_pc, wgdata, wfdata;
  logic [RW-1:0]     wgreg, wfreg;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .RW(RW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .in_rd(in_rd), .done(done),
    .pcenable(pcenable), .next_pc(next_pc), .wgenable(wgenable),
    .wgreg(wgreg), .wgdata(wgdata), .wfenable(wfenable), .wfreg(wfreg),
    .wfdata(wfdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [1:0] sel, input logic [RW-1:0] rd,
                     input logic [XLEN-1:0] data);
    in_valid[ch]          = 1'b1;
    in_sel[2*ch +: 2]     = sel;
    in_rd[RW*ch +: RW]    = rd;
    in_data[XLEN*ch +: XLEN] = data;
  endtask

  int beat, ncommit, npc, cyc;
  logic acc;

  initial begin
    rstn = 1'b0; in_valid = '0; in_sel = '0; in_data = '0; in_rd = '0;
    tick(); tick();
    chk("rst_done", done, 0);
    chk("rst_strobes", {pcenable, wgenable, wfenable}, 0);
    chk("rst_data", {next_pc, wgdata, wfdata}, 0);
    chk("rst_idx", {wgreg, wfreg}, 0);
    chk("rst_ready", in_ready, 3'b111);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;

    // single GPR commit on ch1
    put(1, 2'b10, 5'd7, 32'hDEADBEEF);
    tick(); in_valid = '0;
    chk("gpr_busy_head", busy, 1);
    tick();
    chk("gpr_we", wgenable, 1);
    chk("gpr_reg", wgreg, 7);
    chk("gpr_data", wgdata, 32'hDEADBEEF);
    chk("gpr_done", done, 3'b010);
    tick();
    chk("gpr_we_clear", wgenable, 0);
    chk("gpr_done_clear", done, 0);
    chk("gpr_data_hold", wgdata, 32'hDEADBEEF);

    // x0 suppression, f0 writable
    put(0, 2'b10, 5'd0, 32'h55);
    tick(); in_valid = '0;
    tick();
    chk("x0_done", done, 3'b001);
    chk("x0_we", wgenable, 0);
    tick();
    put(0, 2'b11, 5'd0, 32'h1234);
    tick(); in_valid = '0;
    tick();
    chk("f0_we", wfenable, 1);
    chk("f0_reg", wfreg, 0);
    chk("f0_data", wfdata, 32'h1234);
    chk("f0_done", done, 3'b001);
    tick();

    // reset with entries queued: nothing commits
    put(0, 2'b10, 5'd9, 32'h9); put(1, 2'b10, 5'd9, 32'h9); put(2, 2'b01, 5'd0, 32'h9);
    tick(); in_valid = '0; rstn = 1'b0;
    tick();
    chk("mrst_strobes", {pcenable, wgenable, wfenable}, 0);
    chk("mrst_done", done, 0);
    rstn = 1'b1;
    tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_strobes2", {pcenable, wgenable, wfenable, done}, 0);
    chk("mrst_ready", in_ready, 3'b111);

    // round-robin, two bursts
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < NCH; c++)
        put(c, 2'b10, RW'(3*b + c + 1), 32'hA0 + 32'(3*b + c));
      tick(); in_valid = '0;
      for (int c = 0; c < NCH; c++) begin
        tick();
        chk("rr_done", done, 3'b001 << c);
        chk("rr_reg", wgreg, 3*b + c + 1);
        chk("rr_data", wgdata, 32'hA0 + 32'(3*b + c));
      end
      tick();
      chk("rr_idle", {wgenable, busy}, 0);
    end

    // PC priority over pending GPR entries
    put(0, 2'b10, 5'd10, 32'hC0); put(1, 2'b10, 5'd11, 32'hC1); put(2, 2'b01, 5'd0, 32'h100);
    tick(); in_valid = '0;
    tick();
    chk("pc_en", pcenable, 1);
    chk("pc_val", next_pc, 32'h100);
    chk("pc_done", done, 3'b100);
    chk("pc_no_gpr", wgenable, 0);
    tick();
    chk("pc_then_ch0", {done, wgreg}, {3'b001, 5'd10});
    chk("pc_clear", pcenable, 0);
    tick();
    chk("pc_then_ch1", {done, wgreg}, {3'b010, 5'd11});
    tick();

    // backpressure: ch1 streams PC redirects while ch0 fills
    beat = 0; ncommit = 0; npc = 0; cyc = 0;
    while (ncommit < 4 && cyc < 40) begin
      if (wgenable) begin
        chk("bp_order", wgdata, 32'hB0 + 32'(ncommit));
        chk("bp_done", done, 3'b001);
        ncommit++;
      end
      if (pcenable) npc++;
      in_valid = '0;
      if (beat < 4) put(0, 2'b10, RW'(beat + 1), 32'hB0 + 32'(beat));
      if (cyc < 4) put(1, 2'b01, 5'd0, 32'h200 + 32'(cyc));
      if (cyc == 2) chk("bp_ready_low", in_ready[0], 0);
      acc = in_valid[0] && in_ready[0];
      tick();
      if (acc) beat++;
      cyc++;
    end
    in_valid = '0;
    chk("bp_commits", ncommit, 4);
    chk("bp_pc_commits", npc, 4);
    tick();
    chk("bp_idle", {busy, in_ready}, {1'b0, 3'b111});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
